// File: rtl/led_unlock_ctrl.sv
// Three-code unlock sequencer driving a blinking LED bank once unlocked,
// with a timed lockout after three consecutive failed attempts.
module led_unlock_ctrl #(
  parameter logic [7:0]  K0          = 8'hA5,
  parameter logic [7:0]  K1          = 8'h3C,
  parameter logic [7:0]  K2          = 8'h96,
  parameter logic [27:0] HALF_BASE   = 28'h4000000,
  parameter logic [27:0] LOCKOUT_CYC = 28'hFFFFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key,
  input  logic       key_valid,
  output logic [3:0] led,
  output logic       unlocked,
  output logic       lockout,
  output logic [1:0] fail_cnt
);

  typedef enum logic [2:0] {
    WAIT0    = 3'd0,
    WAIT1    = 3'd1,
    WAIT2    = 3'd2,
    UNLOCKED = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  fail_cnt_r, fail_cnt_s;
  logic [3:0]  mask_r, mask_s;
  logic [1:0]  rate_r, rate_s;
  logic [29:0] blink_cnt_r, blink_cnt_s;
  logic        on_r, on_s;
  logic [27:0] lock_cnt_r, lock_cnt_s;
  logic [3:0]  led_r, led_s;
  logic        unlocked_r, lockout_r;

  logic [29:0] half_s;
  logic        blink_end_s;
  logic [1:0]  fail_step_s;
  logic [7:0]  expect_s;
  state_t      advance_s;

  // Half-period is at most 4 * (2^28 - 1), so 30 bits never overflow.
  assign half_s      = ({28'd0, rate_r} + 30'd1) * {2'b00, HALF_BASE};
  assign blink_end_s = (blink_cnt_r == (half_s - 30'd1));
  assign fail_step_s = fail_cnt_r + 2'd1;

  // Code expected in the current wait state and the state a match leads to.
  always_comb begin
    expect_s  = K0;
    advance_s = WAIT1;
    case (state_r)
      WAIT0: begin
        expect_s  = K0;
        advance_s = WAIT1;
      end
      WAIT1: begin
        expect_s  = K1;
        advance_s = WAIT2;
      end
      WAIT2: begin
        expect_s  = K2;
        advance_s = UNLOCKED;
      end
      default: begin
        expect_s  = K0;
        advance_s = WAIT1;
      end
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_s     = state_r;
    fail_cnt_s  = fail_cnt_r;
    mask_s      = mask_r;
    rate_s      = rate_r;
    blink_cnt_s = blink_cnt_r;
    on_s        = on_r;
    lock_cnt_s  = lock_cnt_r;
    case (state_r)
      WAIT0, WAIT1, WAIT2: begin
        if (key_valid) begin
          if (key == expect_s) begin
            state_s = advance_s;
            if (advance_s == UNLOCKED) begin
              fail_cnt_s  = 2'd0;
              mask_s      = 4'hF;
              rate_s      = 2'd0;
              blink_cnt_s = 30'd0;
              on_s        = 1'b1;
            end else begin
              fail_cnt_s = fail_cnt_r;
            end
          end else begin
            // A failing code never restarts the match, even if it equals K0.
            fail_cnt_s = fail_step_s;
            if (fail_step_s == 2'd3) begin
              state_s    = LOCKOUT;
              lock_cnt_s = 28'd0;
            end else begin
              state_s = WAIT0;
            end
          end
        end else begin
          state_s = state_r;
        end
      end
      UNLOCKED: begin
        if (key_valid && (key == 8'h00)) begin
          state_s = WAIT0;
        end else if (key_valid && (key[7:4] == 4'h1)) begin
          // A rate change wins over a coinciding terminal count: no toggle.
          rate_s      = key[1:0];
          blink_cnt_s = 30'd0;
        end else begin
          if (key_valid && (key[7:4] == 4'hF)) begin
            mask_s = key[3:0];
          end else begin
            mask_s = mask_r;
          end
          if (blink_end_s) begin
            blink_cnt_s = 30'd0;
            on_s        = ~on_r;
          end else begin
            blink_cnt_s = blink_cnt_r + 30'd1;
          end
        end
      end
      LOCKOUT: begin
        if (lock_cnt_r == (LOCKOUT_CYC - 28'd1)) begin
          state_s    = WAIT0;
          fail_cnt_s = 2'd0;
          lock_cnt_s = 28'd0;
        end else begin
          lock_cnt_s = lock_cnt_r + 28'd1;
        end
      end
      default: begin
        state_s    = WAIT0;
        fail_cnt_s = 2'd0;
      end
    endcase
  end

  // LED drive derived from the next state so the registered copy is Moore.
  always_comb begin
    led_s = 4'h0;
    case (state_s)
      UNLOCKED: led_s = mask_s & {4{on_s}};
      LOCKOUT:  led_s = 4'hF;
      default:  led_s = 4'h0;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= WAIT0;
      fail_cnt_r  <= 2'd0;
      mask_r      <= 4'hF;
      rate_r      <= 2'd0;
      blink_cnt_r <= 30'd0;
      on_r        <= 1'b0;
      lock_cnt_r  <= 28'd0;
      led_r       <= 4'h0;
      unlocked_r  <= 1'b0;
      lockout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      fail_cnt_r  <= fail_cnt_s;
      mask_r      <= mask_s;
      rate_r      <= rate_s;
      blink_cnt_r <= blink_cnt_s;
      on_r        <= on_s;
      lock_cnt_r  <= lock_cnt_s;
      led_r       <= led_s;
      unlocked_r  <= (state_s == UNLOCKED);
      lockout_r   <= (state_s == LOCKOUT);
    end
  end

  assign led      = led_r;
  assign unlocked = unlocked_r;
  assign lockout  = lockout_r;
  assign fail_cnt = fail_cnt_r;

endmodule

// File: tb/tb_led_unlock_ctrl.sv
// Self-checking bench for led_unlock_ctrl: directed scenarios plus random
// strobes, all compared against a time-based behavioural model.
module tb_led_unlock_ctrl;

  localparam int HB   = 4;
  localparam int LCYC = 8;
  localparam logic [7:0] C0 = 8'hA5;
  localparam logic [7:0] C1 = 8'h3C;
  localparam logic [7:0] C2 = 8'h96;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key = 8'h00;
  logic       key_valid = 1'b0;
  logic [3:0] led;
  logic       unlocked;
  logic       lockout;
  logic [1:0] fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  led_unlock_ctrl #(
    .K0(C0), .K1(C1), .K2(C2),
    .HALF_BASE(28'd4), .LOCKOUT_CYC(28'd8)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .key_valid(key_valid),
    .led(led), .unlocked(unlocked), .lockout(lockout), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Model: progress through the code, mode flags, and blink phase expressed
  // as elapsed cycles since the last blink epoch divided by the half-period.
  int         m_prog;
  bit         m_unl, m_lock;
  logic [1:0] m_fail;
  int         m_left;
  logic [3:0] m_mask;
  int         m_rate, m_el;
  bit         m_onb;

  function automatic bit m_on();
    return m_onb ^ (((m_el / ((m_rate + 1) * HB)) % 2) == 1);
  endfunction

  function automatic logic [7:0] exp_vec();
    logic [3:0] l;
    if (m_unl) l = m_mask & {4{m_on()}};
    else if (m_lock) l = 4'hF;
    else l = 4'h0;
    return {l, m_unl, m_lock, m_fail};
  endfunction

  function automatic logic [7:0] code_for(input int p);
    return (p == 0) ? C0 : (p == 1) ? C1 : C2;
  endfunction

  task automatic model_step(input bit r, input bit kv, input logic [7:0] k);
    if (r) begin
      m_prog = 0; m_unl = 0; m_lock = 0; m_fail = 2'd0;
      m_mask = 4'hF; m_rate = 0; m_el = 0; m_onb = 0; m_left = 0;
    end else if (m_lock) begin
      m_left--;
      if (m_left == 0) begin
        m_lock = 0; m_fail = 2'd0; m_prog = 0;
      end
    end else if (m_unl) begin
      if (kv && k == 8'h00) begin
        m_unl = 0; m_prog = 0;
      end else if (kv && k[7:4] == 4'h1) begin
        m_onb = m_on(); m_rate = int'(k[1:0]); m_el = 0;
      end else begin
        if (kv && k[7:4] == 4'hF) m_mask = k[3:0];
        m_el++;
      end
    end else if (kv) begin
      if (k == code_for(m_prog)) begin
        m_prog++;
        if (m_prog == 3) begin
          m_unl = 1; m_prog = 0; m_fail = 2'd0; m_mask = 4'hF;
          m_rate = 0; m_el = 0; m_onb = 1;
        end
      end else begin
        m_fail = m_fail + 2'd1; m_prog = 0;
        if (m_fail == 2'd3) begin
          m_lock = 1; m_left = LCYC;
        end
      end
    end
  endtask

  task automatic tick(input bit r, input bit kv, input logic [7:0] k);
    rst = r; key_valid = kv; key = k;
    @(posedge clk);
    model_step(r, kv, k);
    @(negedge clk);
    rst = 1'b0; key_valid = 1'b0; key = 8'h00;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 8'h00);
    n_checks++;
    if ({led, unlocked, lockout, fail_cnt} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset actual=%h expected=00", {led, unlocked, lockout, fail_cnt});
    end
  endtask

  task automatic test_unlock();
    logic [7:0] seq [3];
    seq = '{C0, C1, C2};
    tick(1'b1, 1'b0, 8'h00);
    foreach (seq[i]) begin
      tick(1'b0, 1'b1, seq[i]);
      tick(1'b0, 1'b0, 8'h00);
    end
    // Re-run the sequence back-to-back so the third strobe is the last tick.
    tick(1'b1, 1'b0, 8'h00);
    foreach (seq[i]) tick(1'b0, 1'b1, seq[i]);
    n_checks++;
    if (unlocked !== 1'b1 || led !== 4'hF || fail_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL unlock_entry actual=%b/%h expected=1/f", unlocked, led);
    end
    for (int c = 1; c < 17; c++) begin
      tick(1'b0, 1'b0, 8'h00);
      n_checks++;
      if (led !== ((((c / 4) % 2) == 0) ? 4'hF : 4'h0) ||
          {led, unlocked, lockout, fail_cnt} !== exp_vec()) begin
        n_fail++;
        $display("FAIL blink cyc=%0d actual=%h expected=%h", c,
                 {led, unlocked, lockout, fail_cnt}, exp_vec());
      end
    end
  endtask

  task automatic test_fail_then_unlock();
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, C0);
    tick(1'b0, 1'b1, 8'h11);
    n_checks++;
    if (fail_cnt !== 2'd1 || led !== 4'h0 || unlocked !== 1'b0) begin
      n_fail++;
      $display("FAIL one_failure actual=%0d/%h expected=1/0", fail_cnt, led);
    end
    tick(1'b0, 1'b1, C0);
    tick(1'b0, 1'b1, C1);
    tick(1'b0, 1'b1, C2);
    n_checks++;
    if (unlocked !== 1'b1 || fail_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL unlock_after_fail actual=%b/%0d expected=1/0", unlocked, fail_cnt);
    end
  endtask

  task automatic test_lockout();
    int cnt;
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h01);
    tick(1'b0, 1'b1, 8'h02);
    tick(1'b0, 1'b1, 8'h03);
    n_checks++;
    if (lockout !== 1'b1 || fail_cnt !== 2'd3 || led !== 4'hF) begin
      n_fail++;
      $display("FAIL lockout_entry actual=%b/%0d/%h expected=1/3/f", lockout, fail_cnt, led);
    end
    cnt = 1;
    for (int g = 0; g < 20 && lockout === 1'b1; g++) begin
      tick(1'b0, (g == 1), C0);
      n_checks++;
      if ({led, unlocked, lockout, fail_cnt} !== exp_vec()) begin
        n_fail++;
        $display("FAIL lockout_cyc actual=%h expected=%h",
                 {led, unlocked, lockout, fail_cnt}, exp_vec());
      end
      if (lockout === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt !== LCYC || fail_cnt !== 2'd0 || led !== 4'h0) begin
      n_fail++;
      $display("FAIL lockout_len actual=%0d/%0d expected=%0d/0", cnt, fail_cnt, LCYC);
    end
  endtask

  task automatic test_rate_mask();
    logic [3:0] l0;
    int run;
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, C0);
    tick(1'b0, 1'b1, C1);
    tick(1'b0, 1'b1, C2);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h12);
    l0 = led;
    run = 1;
    for (int g = 0; g < 40 && led === l0; g++) begin
      tick(1'b0, 1'b0, 8'h00);
      if (led === l0) run++;
    end
    n_checks++;
    if (run !== 12) begin
      n_fail++;
      $display("FAIL rate_half_period actual=%0d expected=12", run);
    end
    tick(1'b0, 1'b1, 8'hF5);
    for (int c = 0; c < 30; c++) begin
      tick(1'b0, 1'b0, 8'h00);
      n_checks++;
      if ((led !== 4'h5 && led !== 4'h0) ||
          {led, unlocked, lockout, fail_cnt} !== exp_vec()) begin
        n_fail++;
        $display("FAIL mask_blink actual=%h expected=%h",
                 {led, unlocked, lockout, fail_cnt}, exp_vec());
      end
    end
    tick(1'b0, 1'b1, 8'h00);
    n_checks++;
    if (unlocked !== 1'b0 || led !== 4'h0 || fail_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL relock actual=%b/%h expected=0/0", unlocked, led);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h55);
    tick(1'b0, 1'b1, 8'h66);
    tick(1'b0, 1'b1, 8'h77);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    n_checks++;
    if ({led, unlocked, lockout, fail_cnt} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_lockout actual=%h expected=00", {led, unlocked, lockout, fail_cnt});
    end
    tick(1'b0, 1'b1, C0);
    tick(1'b0, 1'b1, C1);
    tick(1'b0, 1'b1, C2);
    for (int c = 0; c < 6; c++) tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    n_checks++;
    if ({led, unlocked, lockout, fail_cnt} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_blink actual=%h expected=00", {led, unlocked, lockout, fail_cnt});
    end
    tick(1'b0, 1'b1, C0);
    tick(1'b0, 1'b1, C1);
    tick(1'b0, 1'b1, C2);
    n_checks++;
    if (unlocked !== 1'b1 || led !== 4'hF) begin
      n_fail++;
      $display("FAIL unlock_after_reset actual=%b/%h expected=1/f", unlocked, led);
    end
  endtask

  task automatic test_random();
    logic [7:0] k;
    bit kv, r;
    int sel;
    for (int c = 0; c < 1500; c++) begin
      sel = $urandom_range(0, 11);
      if (sel <= 5)      k = code_for(m_prog);
      else if (sel == 6) k = 8'h00;
      else if (sel == 7) k = {4'h1, 4'($urandom_range(0, 15))};
      else if (sel == 8) k = {4'hF, 4'($urandom_range(0, 15))};
      else               k = 8'($urandom_range(0, 255));
      if (m_unl && sel == 6 && $urandom_range(0, 3) != 0) k = 8'h42;
      kv = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 199) == 0);
      tick(r, kv, k);
      n_checks++;
      if ({led, unlocked, lockout, fail_cnt} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d key=%h actual=%h expected=%h", c, k,
                 {led, unlocked, lockout, fail_cnt}, exp_vec());
      end
    end
  endtask

  initial begin
    model_step(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    test_reset();
    test_unlock();
    test_fail_then_unlock();
    test_lockout();
    test_rate_mask();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_unlock_ctrl.md
LED_UNLOCK_CTRL -- requirements
Module: led_unlock_ctrl

Interface
REQ-001 SHALL have parameter K0, default 8'hA5, first unlock code.
REQ-002 SHALL have parameter K1, default 8'h3C, second unlock code.
REQ-003 SHALL have parameter K2, default 8'h96, third unlock code.
REQ-004 SHALL have parameter HALF_BASE, 28 bits, default 28'h4000000, base blink half-period in cycles (must be >= 1).
REQ-005 SHALL have parameter LOCKOUT_CYC, 28 bits, default 28'hFFFFFFF, lockout duration in cycles (must be >= 1).
REQ-006 SHALL have port clk, input, 1 bit, clock; all state updates on rising edge.
REQ-007 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port key, input, 8 bits, code or command, sampled only when key_valid=1.
REQ-009 SHALL have port key_valid, input, 1 bit, one-cycle strobe qualifying key.
REQ-010 SHALL have port led, output, 4 bits, LED drive.
REQ-011 SHALL have port unlocked, output, 1 bit, high in state UNLOCKED.
REQ-012 SHALL have port lockout, output, 1 bit, high in state LOCKOUT.
REQ-013 SHALL have port fail_cnt, output, 2 bits, consecutive failed attempts.

Function
REQ-014 SHALL implement states WAIT0, WAIT1, WAIT2, UNLOCKED, LOCKOUT; all outputs are registered state or decoded from registered state (Moore).
REQ-015 SHALL, in WAIT0/WAIT1/WAIT2, on key_valid with key==K0/K1/K2 respectively, advance to WAIT1/WAIT2/UNLOCKED on that edge.
REQ-016 SHALL, in WAIT0/WAIT1/WAIT2, on key_valid with a non-matching key, go to WAIT0 and increment fail_cnt; no restart-match against K0 on the failing code.
REQ-017 SHALL, when a failure makes fail_cnt reach 3, enter LOCKOUT instead of WAIT0, holding fail_cnt=3.
REQ-018 SHALL, on entry to UNLOCKED, clear fail_cnt to 0, set mask=4'hF, rate=0, blink counter=0, on=1.
REQ-019 SHALL remain in LOCKOUT for exactly LOCKOUT_CYC cycles (counter 0..LOCKOUT_CYC-1), then enter WAIT0 with fail_cnt=0.
REQ-020 SHALL ignore key_valid entirely in LOCKOUT (no count, no state change).
REQ-021 SHALL, in UNLOCKED, use half-period H=(rate+1)*HALF_BASE, computed in 30 bits without overflow; the blink counter counts 0..H-1 and on toggles with counter reset to 0 when counter==H-1.
REQ-022 SHALL, in UNLOCKED, on key_valid with key==8'h00, go to WAIT0 (relock), fail_cnt unchanged at 0.
REQ-023 SHALL, in UNLOCKED, on key_valid with key[7:4]==4'h1, set rate=key[1:0] and clear blink counter; on unchanged.
REQ-024 SHALL, in UNLOCKED, on key_valid with key[7:4]==4'hF, set mask=key[3:0]; blink counter and on unaffected.
REQ-025 SHALL, in UNLOCKED, ignore key_valid with any other key value.
REQ-026 SHALL drive led = mask & {4{on}} in UNLOCKED, 4'b1111 in LOCKOUT, 4'b0000 in WAIT0/WAIT1/WAIT2.
REQ-027 SHALL, if a rate command and the counter terminal cycle coincide, apply the command (counter=0, no toggle).

Reset
REQ-028 SHALL, when rst=1 at a clock edge, take priority over all inputs and set state=WAIT0, fail_cnt=0, mask=4'hF, rate=0, all counters=0, on=0, giving led=0, unlocked=0, lockout=0 from the next cycle, including mid-lockout or mid-blink.

Verification (HALF_BASE=4, LOCKOUT_CYC=8)
REQ-029 SHALL cover: strobes A5,3C,96 -> unlocked=1 the cycle after the third strobe, led=4'hF for 4 cycles then 4'h0 for 4 cycles, repeating.
REQ-030 SHALL cover: A5 then 11 -> WAIT0, fail_cnt=1, led=0; then A5,3C,96 -> unlocked, fail_cnt=0.
REQ-031 SHALL cover: three wrong codes (e.g. 01,02,03) -> lockout=1, fail_cnt=3, led=4'hF for exactly 8 cycles, strobe A5 during lockout ignored, then WAIT0 with fail_cnt=0.
REQ-032 SHALL cover: unlocked, strobe 12 -> half-period 12 cycles; strobe F5 -> led alternates 4'b0101/4'b0000; strobe 00 -> unlocked=0, led=0.
REQ-033 SHALL cover: rst=1 for one cycle mid-lockout and mid-blink -> all outputs zero next cycle, A5,3C,96 then unlocks normally.
